bcd_serial_add_ctrl: RTL and testbench
======================================

Name: bcd_serial_add_ctrl

Overview:
- Sequences a multi-digit packed-BCD addition one digit per clock.
- The digit datapath is internal: 4-bit A, B and carry-in; binary add; +6 correction when the sum exceeds 9.
- The controller latches the operands, walks the digits LSD to MSD, propagates the carry, and presents the packed result with a done pulse.
- Sits between the operand source (keypad/register logic) and the display/result consumer, where a full-width parallel BCD adder is not wanted.

Parameters:
- DIGITS, 4: number of BCD digits per operand (1..16).
- IDXW, 4: digit-index counter width; must satisfy 2^IDXW >= DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to add; sampled on the rising edge of clk.
- a_bcd  input  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0].
- b_bcd  input  4*DIGITS  operand B, packed BCD.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum_bcd and carry_out are valid.
- sum_bcd  output  4*DIGITS  packed BCD result; held until the next accepted start.
- carry_out  output  1  carry out of the MSD.
- invalid  output  1  set if any operand nibble was >9 in the current operation.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, carry=0, busy=0, done=0, sum_bcd=0, carry_out=0, invalid=0, operand registers=0.
  - A reset mid-operation aborts the addition with no done pulse.
  - On rst_n release the block waits for a fresh start.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 -> latch a_bcd/b_bcd into shift registers, clear carry, idx=0, clear sum_bcd, clear invalid, go to ADD.
  - start=0 -> stay.
- ADD (busy=1), each cycle:
  - Take low nibbles a, b of the shift registers and compute s = a + b + carry (5-bit, range 0..31).
  - If s > 9: digit = (s + 6) mod 16, next carry = 1. Otherwise digit = s[3:0], next carry = 0.
  - Shift digit into sum_bcd from the MSD side (right shift by 4, insert at top), so after DIGITS cycles digit 0 sits at bits [3:0].
  - Shift both operand registers right by 4.
  - If a > 9 or b > 9, set invalid (sticky until the next start).
  - idx increments; when idx == DIGITS-1 the next state is DONE.
- DONE: one cycle only.
  - done=1, busy=0, carry_out = final carry.
  - Then go to IDLE, or if start=1 in this cycle accept it directly (same as the IDLE accept path) and go to ADD.
- Latency: start sampled at edge N -> done high during cycle N+DIGITS+1 (N+1..N+DIGITS are ADD cycles).
- Throughput: one operation every DIGITS+1 cycles with back-to-back starts.
- start while busy=1 (ADD) is ignored. It is not queued, and input operand changes during ADD have no effect.
- Output holds:
  - sum_bcd and carry_out change only during ADD/accept and hold after DONE until the next accepted start.
  - carry_out is cleared on accept.
  - sum_bcd is not valid to consumers while busy=1.
- Invalid digits still produce a defined result under the rule above. No abort, no saturation.
- DIGITS=1 is legal: one ADD cycle, then DONE.

Test Plan (DIGITS=4):
- Basic add: reset, start with a=0x1234, b=0x5678 -> busy for 4 cycles, done pulse on cycle 5 after start, sum_bcd=0x6912, carry_out=0, invalid=0.
- Full carry ripple: a=0x9999, b=0x0001 -> sum_bcd=0x0000, carry_out=1. Then a=0x9999, b=0x9999 -> sum_bcd=0x9998, carry_out=1.
- Invalid operand and back-to-back start:
  - a=0x00A0, b=0x0005 -> invalid=1, sum_bcd=0x0105 (digit 1: 10 > 9 -> 0, carry 1), carry_out=0.
  - Next op a=0x0001, b=0x0001 started in the DONE cycle -> invalid clears to 0, sum_bcd=0x0002.
- Start while busy: assert start again with a=0x1111 at cycle 2 of an ADD of 0x0005+0x0005 -> ignored; result 0x0010; exactly one done pulse.
- Reset mid-operation: assert rst_n low during ADD cycle 2 (not clock-aligned) -> all outputs 0 immediately, no done pulse. After release, start 0x0042+0x0058 -> 0x0100.
- Hold check: after done, change a_bcd/b_bcd with start=0 for 10 cycles -> sum_bcd, carry_out and invalid stay constant, busy=0, done=0.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller: latches two operands, adds one BCD
// digit per clock from LSD to MSD, then presents the sum with a one-cycle done pulse.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum_bcd,
    output logic                  carry_out,
    output logic                  invalid
);

    localparam int W = 4 * DIGITS;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
    logic             invalid_q, invalid_d;

    logic [3:0]       dig_a, dig_b, digit;
    logic [4:0]       raw_sum, adj_sum;
    logic             carry_next;
    logic             accept;

    // Single-digit BCD adder; the +6 correction wraps mod 16 even for illegal digits.
    always_comb begin
        dig_a   = a_q[3:0];
        dig_b   = b_q[3:0];
        raw_sum = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
        adj_sum = raw_sum + 5'd6;
        if (raw_sum > 5'd9) begin
            digit      = adj_sum[3:0];
            carry_next = 1'b1;
        end else begin
            digit      = raw_sum[3:0];
            carry_next = 1'b0;
        end
    end

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        invalid_d   = invalid_q;

        case (state_q)
            IDLE: state_d = IDLE;
            ADD: begin
                // New digits enter at the MSD end so digit 0 lands at bits [3:0] last.
                sum_d   = (sum_q >> 4) | (W'(digit) << (W - 4));
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = carry_next;
                idx_d   = idx_q + IDXW'(1);
                if ((dig_a > 4'd9) || (dig_b > 4'd9)) begin
                    invalid_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    carry_out_d = carry_next;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d     = ADD;
            idx_d       = '0;
            carry_d     = 1'b0;
            a_d         = a_bcd;
            b_d         = b_bcd;
            sum_d       = '0;
            carry_out_d = 1'b0;
            invalid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            invalid_q   <= invalid_d;
        end
    end

    assign busy      = (state_q == ADD);
    assign done      = (state_q == DONE);
    assign sum_bcd   = sum_q;
    assign carry_out = carry_out_q;
    assign invalid   = invalid_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them whenever done is presented.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_bcd, b_bcd;
    logic         busy, done, carry_out, invalid;
    logic [W-1:0] sum_bcd;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         inv;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   done_count = 0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS), .IDXW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_bcd     (a_bcd),
        .b_bcd     (b_bcd),
        .busy      (busy),
        .done      (done),
        .sum_bcd   (sum_bcd),
        .carry_out (carry_out),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got sum 0x%0h, expected no done", sum_bcd);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sum_bcd",   32'(sum_bcd),   32'(e.sum));
                    checkOutput("carry_out", 32'(carry_out), 32'(e.cout));
                    checkOutput("invalid",   32'(invalid),   32'(e.inv));
                    checkOutput("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    // Drives one start cycle; caller positions time away from the clock edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit push, input logic [W-1:0] es,
                                 input bit ec, input bit ei);
        exp_t e;
        start = 1'b1;
        a_bcd = a;
        b_bcd = b;
        if (push) begin
            e.sum  = es;
            e.cout = ec;
            e.inv  = ei;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected done", lat);
        end
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input bit ec, input bit ei);
        int lat, bc;
        applyStimulus(a, b, 1'b1, es, ec, ei);
        waitDone(lat, bc);
        checkOutput("latency",     32'(lat), 32'(DIGITS + 1));
        checkOutput("busy_cycles", 32'(bc),  32'(DIGITS));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, bc, dc0;
        rst_n = 1'b0;
        start = 1'b0;
        a_bcd = '0;
        b_bcd = '0;
        #12;
        checkOutput("rst_busy",    32'(busy),      32'd0);
        checkOutput("rst_done",    32'(done),      32'd0);
        checkOutput("rst_sum",     32'(sum_bcd),   32'd0);
        checkOutput("rst_cout",    32'(carry_out), 32'd0);
        checkOutput("rst_invalid", 32'(invalid),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        runOp(16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0);
        @(posedge clk); #1;
        runOp(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0);
        @(posedge clk); #1;
        runOp(16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Invalid digit, then a new start accepted during the DONE cycle.
        applyStimulus(16'h00A0, 16'h0005, 1'b1, 16'h0105, 1'b0, 1'b1);
        waitDone(lat, bc);
        applyStimulus(16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0);
        waitDone(lat, bc);
        checkOutput("b2b_latency", 32'(lat), 32'(DIGITS + 1));
        @(posedge clk); #1;

        // Start during ADD must be ignored.
        dc0 = done_count;
        applyStimulus(16'h0005, 16'h0005, 1'b1, 16'h0010, 1'b0, 1'b0);
        @(posedge clk); #1;
        applyStimulus(16'h1111, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0);
        waitDone(lat, bc);
        repeat (8) @(negedge clk);
        checkOutput("single_done", 32'(done_count - dc0), 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset in the second ADD cycle aborts the operation.
        dc0 = done_count;
        applyStimulus(16'h123A, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #3;
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy",    32'(busy),      32'd0);
        checkOutput("mid_rst_done",    32'(done),      32'd0);
        checkOutput("mid_rst_sum",     32'(sum_bcd),   32'd0);
        checkOutput("mid_rst_cout",    32'(carry_out), 32'd0);
        checkOutput("mid_rst_invalid", 32'(invalid),   32'd0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("no_done_after_abort", 32'(done_count - dc0), 32'd0);
        @(posedge clk); #1;
        runOp(16'h0042, 16'h0058, 16'h0100, 1'b0, 1'b0);

        // Outputs hold while operands wander and start stays low.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a_bcd = W'($urandom);
            b_bcd = W'($urandom);
            @(negedge clk);
            checkOutput("hold_sum",     32'(sum_bcd),   32'h0100);
            checkOutput("hold_cout",    32'(carry_out), 32'd0);
            checkOutput("hold_invalid", 32'(invalid),   32'd0);
            checkOutput("hold_busy",    32'(busy),      32'd0);
            checkOutput("hold_done",    32'(done),      32'd0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
